// File: rtl/buzzer_pkg.sv
// Shared types and default 50 MHz timing constants for the buzzer scheduler.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Numeric order doubles as priority: a larger code preempts a smaller one.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_KEY   = 2'd1,
        SRC_TIMER = 2'd2,
        SRC_ALARM = 2'd3
    } src_t;

    localparam int DEF_BEEP_ON     = 12500000;
    localparam int DEF_BEEP_OFF    = 12500000;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TIMER_BEEPS = 3;
    localparam int DEF_ALARM_MAX   = 120;
    localparam int DEF_BEEP_W      = 8;

endpackage

// File: rtl/buzzer_scheduler_beep_phase_timer.sv
// Loadable phase up-counter: clears to 0 on clr, otherwise counts; done once cnt >= last.
module beep_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] last,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // >= rather than == so a stale count past the limit still terminates the phase.
    assign done = (cnt_q >= last);

endmodule

// File: rtl/buzzer_scheduler.sv
// Buzzer sequencer arbitrating alarm / timer / key beep patterns onto buzz_en.
// Optional macro BUZZER_MUTE_EN adds a mute input that silences buzz_en and drops key clicks.
module buzzer_scheduler
    import buzzer_pkg::*;
#(
    parameter int BEEP_ON     = DEF_BEEP_ON,
    parameter int BEEP_OFF    = DEF_BEEP_OFF,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMER_BEEPS = DEF_TIMER_BEEPS,
    parameter int ALARM_MAX   = DEF_ALARM_MAX,
    parameter int BEEP_W      = DEF_BEEP_W
) (
    input  logic       clk,
    input  logic       rst,
    // All request and ack inputs are single-cycle pulses; no handshake back.
    input  logic       req_alarm,
    input  logic       req_timer,
    input  logic       req_key,
    input  logic       ack,
`ifdef BUZZER_MUTE_EN
    input  logic       mute,
`endif
    output logic       buzz_en,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF - 1);

    state_t            state_q, state_d;
    src_t              src_q, src_d;
    src_t              req_src;
    logic [BEEP_W-1:0] beep_q, beep_d;
    logic              pend_q, pend_d;
    logic              buzz_q, buzz_d;
    logic              busy_q, busy_d;
    logic              phase_clr;
    logic              phase_done;
    logic              seq_done;
    logic              req_key_eff;
    logic [CNT_W-1:0]  phase_last;

`ifdef BUZZER_MUTE_EN
    assign req_key_eff = req_key & ~mute;
    assign buzz_en     = buzz_q & ~mute;
`else
    assign req_key_eff = req_key;
    assign buzz_en     = buzz_q;
`endif

    assign busy       = busy_q;
    assign active_src = src_q;
    assign phase_last = (state_q == ON) ? ON_LAST : OFF_LAST;

    beep_phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk (clk),
        .rst (rst),
        .clr (phase_clr),
        .last(phase_last),
        .done(phase_done)
    );

    always_comb begin
        seq_done = 1'b1;
        case (src_q)
            SRC_KEY:   seq_done = (beep_q >= BEEP_W'(1));
            SRC_TIMER: seq_done = (beep_q >= BEEP_W'(TIMER_BEEPS));
            SRC_ALARM: seq_done = (ALARM_MAX != 0) && (beep_q >= BEEP_W'(ALARM_MAX));
            default:   seq_done = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        beep_d    = beep_q;
        pend_d    = pend_q;
        phase_clr = 1'b0;
        req_src   = req_alarm   ? SRC_ALARM :
                    req_timer   ? SRC_TIMER :
                    req_key_eff ? SRC_KEY   : SRC_NONE;

        if (ack && (src_q == SRC_TIMER || src_q == SRC_ALARM)) begin
            state_d   = IDLE;
            src_d     = SRC_NONE;
            beep_d    = '0;
            pend_d    = 1'b0;
            phase_clr = 1'b1;
        end else if (state_q == IDLE) begin
            phase_clr = 1'b1;
            beep_d    = '0;
            if (req_alarm) begin
                state_d = ON;
                src_d   = SRC_ALARM;
                pend_d  = pend_q | req_timer;
            end else if (req_timer || pend_q) begin
                state_d = ON;
                src_d   = SRC_TIMER;
                pend_d  = 1'b0;
            end else if (req_key_eff) begin
                state_d = ON;
                src_d   = SRC_KEY;
            end
        end else if (req_src > src_q) begin
            state_d   = ON;
            src_d     = req_src;
            beep_d    = '0;
            phase_clr = 1'b1;
            // A timer displaced by (or arriving alongside) an alarm is replayed later.
            if (req_src == SRC_ALARM && (src_q == SRC_TIMER || req_timer)) begin
                pend_d = 1'b1;
            end
        end else begin
            if (req_timer) begin
                pend_d = 1'b1;
            end
            if (state_q == ON && phase_done) begin
                state_d   = OFF;
                beep_d    = beep_q + BEEP_W'(1);
                phase_clr = 1'b1;
            end else if (state_q == OFF && phase_done) begin
                phase_clr = 1'b1;
                if (seq_done) begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                    beep_d  = '0;
                end else begin
                    state_d = ON;
                end
            end
        end

        buzz_d = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= SRC_NONE;
            beep_q  <= '0;
            pend_q  <= 1'b0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            beep_q  <= beep_d;
            pend_q  <= pend_d;
            buzz_q  <= buzz_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: directed plan scenarios plus random pulses against an elapsed-time model.
module tb_buzzer_scheduler;

    localparam int ON_T   = 4;
    localparam int OFF_T  = 2;
    localparam int PER    = ON_T + OFF_T;
    localparam int TBEEPS = 3;
    localparam int AMAX   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_alarm = 1'b0;
    logic       req_timer = 1'b0;
    logic       req_key = 1'b0;
    logic       ack = 1'b0;
    logic       buzz_en;
    logic       busy;
    logic [1:0] active_src;

    logic [3:0] exp_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;

    // Reference model: which source owns the buzzer and how long since its sequence began.
    int m_src = 0;
    int m_e = 0;
    int m_pend = 0;

    buzzer_scheduler #(
        .BEEP_ON(ON_T), .BEEP_OFF(OFF_T), .CNT_W(24),
        .TIMER_BEEPS(TBEEPS), .ALARM_MAX(AMAX), .BEEP_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_alarm(req_alarm),
        .req_timer(req_timer),
        .req_key(req_key),
        .ack(ack),
`ifdef BUZZER_MUTE_EN
        .mute(1'b0),
`endif
        .buzz_en(buzz_en),
        .busy(busy),
        .active_src(active_src)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int target_beeps(input int src);
        case (src)
            1:       return 1;
            2:       return TBEEPS;
            3:       return (AMAX == 0) ? 32'h7fff_ffff : AMAX;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_out();
        if (m_src == 0) return 4'b0000;
        return {((m_e % PER) < ON_T), 1'b1, 2'(m_src)};
    endfunction

    task automatic model_step(input logic ra, input logic rt, input logic rk, input logic ak);
        int win;
        win = ra ? 3 : (rt ? 2 : (rk ? 1 : 0));
        if (ak && m_src >= 2) begin
            m_src = 0;
            m_pend = 0;
        end else if (m_src == 0) begin
            if (ra) begin
                m_src = 3; m_e = 0;
                if (rt) m_pend = 1;
            end else if (rt || m_pend != 0) begin
                m_src = 2; m_e = 0; m_pend = 0;
            end else if (rk) begin
                m_src = 1; m_e = 0;
            end
        end else if (win > m_src) begin
            if (win == 3 && (m_src == 2 || rt)) m_pend = 1;
            m_src = win;
            m_e = 0;
        end else begin
            if (rt) m_pend = 1;
            m_e = m_e + 1;
            if (m_e >= target_beeps(m_src) * PER) m_src = 0;
        end
    endtask

    task automatic apply(input logic ra, input logic rt, input logic rk, input logic ak);
        @(negedge clk);
        req_alarm = ra;
        req_timer = rt;
        req_key   = rk;
        ack       = ak;
        model_step(ra, rt, rk, ak);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_now(input string name, input logic [3:0] exp);
        n_vec++;
        if ({buzz_en, busy, active_src} !== exp) begin
            n_miss++;
            $display("FAIL %s: got buzz/busy/src=%b required %b", name, {buzz_en, busy, active_src}, exp);
        end
    endtask

    // Monitor: one expected output word per clock, compared just after the edge.
    initial begin
        logic [3:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                n_vec++;
                if ({buzz_en, busy, active_src} !== exp) begin
                    n_miss++;
                    $display("FAIL cycle_out @%0d: got buzz/busy/src=%b required %b",
                             cyc, {buzz_en, busy, active_src}, exp);
                end
            end
        end
    end

    initial begin
        int k;
        #3;
        check_now("reset_state", 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle(5);
        apply(0, 0, 1, 0); idle(10);              // key click
        apply(0, 1, 0, 0); idle(22);              // timer, three beeps
        apply(1, 0, 0, 0); idle(34);              // alarm runs to ALARM_MAX
        apply(1, 0, 0, 0); idle(8);               // alarm stopped by ack
        apply(0, 0, 0, 1); idle(4);
        apply(0, 1, 0, 0); idle(2);               // timer preempted by alarm, replayed later
        apply(1, 0, 0, 0); idle(60);
        apply(1, 0, 1, 0); idle(3);               // key loses to simultaneous alarm
        apply(0, 0, 0, 1); idle(3);
        apply(0, 0, 0, 1); idle(1);               // ack in idle
        apply(0, 0, 1, 0); idle(1);               // ack during key has no effect
        apply(0, 0, 0, 1); idle(8);
        apply(1, 1, 0, 0); idle(60);              // alarm + timer together
        apply(0, 1, 0, 0); idle(5);               // ack beats same-cycle alarm
        apply(1, 0, 0, 1); idle(5);
        apply(0, 1, 0, 0); idle(3);               // second timer while timer runs
        apply(0, 1, 0, 0); idle(45);

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0);
        end
        idle(70);

        apply(0, 0, 1, 0); idle(2);               // async reset in the middle of a beep
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst", 4'b0000);
        m_src = 0; m_e = 0; m_pend = 0;
        @(negedge clk);
        rst = 1'b0;
        apply(0, 1, 0, 0); idle(20);

        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
